// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix memory loader.
// Holds the loader FSM state type and the default memory geometry:
// DATA_W-bit words, ADDR_W-bit addresses, DEPTH = 2**ADDR_W words.
package matrix_loader_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loader_state_t;

endpackage

// File: rtl/matrix_mem16x8.sv
// Register file backing the matrix memory.
// One synchronous write port and one purely combinational read port.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low clear of every word
//   we        - write enable
//   wadr      - write address
//   wdata     - write data
//   rd_adress - read address
//   rd_data   - mem[rd_adress], combinational. A same-cycle write to the
//               same address is only visible after the clock edge.
module matrix_mem16x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rd_adress,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] words;

    // Each word is a plain register so the whole array can be cleared
    // asynchronously by reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] word_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    word_q <= '0;
                end else if (we && (wadr == ADDR_W'(gi))) begin
                    word_q <= wdata;
                end
            end

            assign words[gi] = word_q;
        end
    endgenerate

    assign rd_data = words[rd_adress];

endmodule

// File: rtl/matrix_memory_loader.sv
// Writer side of the matrix memory read by the 2x2 determinant calculator.
// Accepts a byte stream over valid/ready and writes it into a 16-word
// memory starting at load_adress, wrapping 15 -> 0. When the last byte of
// a load has been written, load_done and start_calc pulse for one cycle.
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   load_start             - load request, sampled only while idle
//   load_adress/load_count - first address and word count (0..16)
//   in_valid/in_data       - stream byte; in_ready - byte accepted this cycle
//   rd_adress/rd_data      - combinational read port for the calculator
//   busy                   - high while loading or signalling completion
//   load_done/start_calc   - one-cycle completion pulse
module matrix_memory_loader #(
    parameter int DATA_W = matrix_loader_pkg::DATA_W,
    parameter int ADDR_W = matrix_loader_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_adress,
    input  logic [ADDR_W:0]   load_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_adress,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              load_done,
    output logic              start_calc
);

    import matrix_loader_pkg::*;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        we          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = LOAD;
                        ptr_d       = load_adress;
                        remaining_d = load_count;
                    end
                end
            end
            LOAD: begin
                // in_ready_q is high exactly while in LOAD.
                if (in_valid && in_ready_q) begin
                    we          = 1'b1;
                    ptr_d       = ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they describe.
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    matrix_mem16x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock     (clock),
        .reset     (reset),
        .we        (we),
        .wadr      (ptr_q),
        .wdata     (in_data),
        .rd_adress (rd_adress),
        .rd_data   (rd_data)
    );

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign load_done  = done_q;
    assign start_calc = done_q;

endmodule
